// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one variable-latency memory port between the instruction fetch
// stage and the memory stage of the pipelined OTTER core. It picks one
// requester at a time and runs the MEM_REQ/MEM_ACK handshake. It returns
// read data with a one-cycle Done pulse. It produces the fetch and
// memory-stage stall signals that freeze the pipeline while an access is
// outstanding.
//
// Arbitration: data wins over fetch, except that data is never granted
// twice in a row while a fetch is waiting. A requester whose Done pulse is
// high in the current cycle is ignored, because its request line still
// shows the access that just finished.
//
// Ports:
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   IReqF, IAddrF         fetch request (level) and address
//   InstrF, IDoneF        fetched word, one-cycle fetch completion pulse
//   StallF                IReqF & ~IDoneF
//   DReqM, MemWriteM      data request (level), 1 = store / 0 = load
//   ALUResultM            data address
//   WriteDataM            store data
//   MemSizeM, MemSignM    access size (0 byte, 1 half, 2 word), load sign flag
//   ReadDataM, DDoneM     load data, one-cycle data completion pulse
//   StallM                DReqM & ~DDoneM
//   MEM_REQ               request to memory, held until MEM_ACK is sampled
//   MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE, MEM_SIGN
//                         registered command, stable while MEM_REQ is high
//   MEM_ACK, MEM_RDATA    memory completion and same-cycle read data
//   ERR                   sticky access-timeout flag
//
// Build option:
//   MEM_TIMEOUT_EN        when defined, an access left unacknowledged for
//                         TIMEOUT busy cycles is abandoned. It completes
//                         with data 0 and sets ERR until reset. When
//                         undefined, an access waits forever and ERR is 0.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IReqF,
    input  logic [31:0] IAddrF,
    output logic [31:0] InstrF,
    output logic        IDoneF,
    output logic        StallF,
    input  logic        DReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignM,
    output logic [31:0] ReadDataM,
    output logic        DDoneM,
    output logic        StallM,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant_d;   // 1 when the most recent grant went to data
    logic        grant_i;
    logic        grant_d;
    logic        finish;         // access ends this cycle (ack or timeout)
    logic        timed_out;
    logic        elig_i;
    logic        elig_d;
    logic [31:0] resp_data;

    // A request whose Done pulse is high this cycle is the one that just
    // finished, so it must not be granted again.
    assign elig_i = IReqF & ~IDoneF;
    assign elig_d = DReqM & ~DDoneM;

    assign StallF = IReqF & ~IDoneF;
    assign StallM = DReqM & ~DDoneM;

    // An abandoned access returns zero instead of whatever is on the bus.
    assign resp_data = timed_out ? 32'h0000_0000 : MEM_RDATA;

`ifdef MEM_TIMEOUT_EN
    // The counter only has to reach TIMEOUT-1, where the timeout fires.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timed_out = (state != IDLE) && !MEM_ACK &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

    // The counter is held at zero in IDLE, so every grant starts it fresh.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (!MEM_ACK) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ERR = err_q;
`else
    assign timed_out = 1'b0;
    assign ERR       = 1'b0;

    // TIMEOUT is only meaningful with the watchdog compiled in.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state is always assigned with <=. Every flop
            // then samples the pre-edge values, whatever order the
            // always blocks run in.
            state <= state_next;
        end
    end

    // Arbitration and next-state logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first. No path can
        // then leave a signal unassigned and infer a latch.
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (elig_d && !(last_grant_d && elig_i)) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (elig_i) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (MEM_ACK || timed_out) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory command, returned data and completion pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_REQ      <= 1'b0;
            MEM_WE       <= 1'b0;
            MEM_ADDR     <= '0;
            MEM_WDATA    <= '0;
            MEM_SIZE     <= '0;
            MEM_SIGN     <= 1'b0;
            InstrF       <= '0;
            ReadDataM    <= '0;
            IDoneF       <= 1'b0;
            DDoneM       <= 1'b0;
            last_grant_d <= 1'b0;
        end else begin
            IDoneF <= 1'b0;
            DDoneM <= 1'b0;

            if (grant_d) begin
                MEM_REQ      <= 1'b1;
                MEM_WE       <= MemWriteM;
                MEM_ADDR     <= ALUResultM;
                MEM_WDATA    <= WriteDataM;
                MEM_SIZE     <= MemSizeM;
                MEM_SIGN     <= MemSignM;
                last_grant_d <= 1'b1;
            end else if (grant_i) begin
                MEM_REQ      <= 1'b1;
                MEM_WE       <= 1'b0;
                MEM_ADDR     <= IAddrF;
                MEM_WDATA    <= '0;
                MEM_SIZE     <= 2'd2;
                MEM_SIGN     <= 1'b0;
                last_grant_d <= 1'b0;
            end

            if (finish) begin
                MEM_REQ <= 1'b0;
                if (state == BUSY_I) begin
                    IDoneF <= 1'b1;
                    InstrF <= resp_data;
                end else begin
                    DDoneM <= 1'b1;
                    // A store returns nothing, so ReadDataM keeps its value.
                    if (!MEM_WE) begin
                        ReadDataM <= resp_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A transaction-level reference model tracks
// which access is in flight, whose turn it is and what each requester
// should see. A compare process checks every DUT output against it on each
// falling edge. Directed scenarios pin the model with literal values. A
// long randomized run then follows: requesters that obey the hold-until-
// Done rule, a memory with random latency, stray acknowledges and
// occasional resets.
// Define MEM_TIMEOUT_EN to build and exercise the watchdog with TIMEOUT = 4.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_sign;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [31:0] instr_f;
    logic        idone_f;
    logic        stall_f;
    logic [31:0] rdata_m;
    logic        ddone_m;
    logic        stall_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic        err;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .CLK        (clk),
        .RST        (rst),
        .IReqF      (i_req),
        .IAddrF     (i_addr),
        .InstrF     (instr_f),
        .IDoneF     (idone_f),
        .StallF     (stall_f),
        .DReqM      (d_req),
        .MemWriteM  (d_we),
        .ALUResultM (d_addr),
        .WriteDataM (d_wdata),
        .MemSizeM   (d_size),
        .MemSignM   (d_sign),
        .ReadDataM  (rdata_m),
        .DDoneM     (ddone_m),
        .StallM     (stall_m),
        .MEM_REQ    (mem_req),
        .MEM_WE     (mem_we),
        .MEM_ADDR   (mem_addr),
        .MEM_WDATA  (mem_wdata),
        .MEM_SIZE   (mem_size),
        .MEM_SIGN   (mem_sign),
        .MEM_ACK    (mem_ack),
        .MEM_RDATA  (mem_rdata),
        .ERR        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one access record plus what each requester sees.
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          sign;
    } access_t;

    access_t     cur;
    bit          m_busy, m_last_d, m_idone, m_ddone, m_err;
    bit          m_idone_prev, m_ddone_prev;
    logic [31:0] m_instr, m_rdata;
    bit          want_i, want_d, fin, pick_d;
    logic [31:0] resp;
`ifdef MEM_TIMEOUT_EN
    int          m_wait;
`endif

    always @(posedge clk) begin
        m_idone_prev = m_idone;
        m_ddone_prev = m_ddone;
        if (rst) begin
            m_busy   = 1'b0;
            m_last_d = 1'b0;
            m_idone  = 1'b0;
            m_ddone  = 1'b0;
            m_err    = 1'b0;
            m_instr  = '0;
            m_rdata  = '0;
        end else begin
            want_i  = i_req && !m_idone;
            want_d  = d_req && !m_ddone;
            m_idone = 1'b0;
            m_ddone = 1'b0;
            if (m_busy) begin
                fin  = mem_ack;
                resp = mem_rdata;
`ifdef MEM_TIMEOUT_EN
                if (!mem_ack) begin
                    m_wait++;
                    if (m_wait >= TO) begin
                        fin   = 1'b1;
                        resp  = '0;
                        m_err = 1'b1;
                    end
                end
`endif
                if (fin) begin
                    m_busy = 1'b0;
                    if (cur.is_d) begin
                        m_ddone = 1'b1;
                        if (!cur.we) m_rdata = resp;
                    end else begin
                        m_idone = 1'b1;
                        m_instr = resp;
                    end
                end
            end else if (want_i || want_d) begin
                // Data first, unless data was served last and fetch waits.
                pick_d = want_d && !(m_last_d && want_i);
                cur.is_d  = pick_d;
                cur.we    = pick_d ? d_we : 1'b0;
                cur.addr  = pick_d ? d_addr : i_addr;
                cur.wdata = d_wdata;
                cur.size  = pick_d ? d_size : 2'd2;
                cur.sign  = pick_d ? d_sign : 1'b0;
                m_busy    = 1'b1;
                m_last_d  = pick_d;
`ifdef MEM_TIMEOUT_EN
                m_wait    = 0;
`endif
            end
        end
    end

    // Compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check_b("MEM_REQ", mem_req, m_busy);
            if (m_busy) begin
                check_b("MEM_WE", mem_we, cur.we);
                check_w("MEM_ADDR", mem_addr, cur.addr);
                check_w("MEM_SIZE", 32'(mem_size), 32'(cur.size));
                check_b("MEM_SIGN", mem_sign, cur.sign);
                if (cur.is_d) check_w("MEM_WDATA", mem_wdata, cur.wdata);
            end
            check_b("IDoneF", idone_f, m_idone);
            check_b("DDoneM", ddone_m, m_ddone);
            check_w("InstrF", instr_f, m_instr);
            check_w("ReadDataM", rdata_m, m_rdata);
            check_b("ERR", err, m_err);
            check_b("StallF", stall_f, i_req & ~m_idone);
            check_b("StallM", stall_m, d_req & ~m_ddone);
        end
    end

    // Start of a new cycle: just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int dd_cnt, id_cnt;

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_size = '0; d_sign = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        #2;
        check_b("reset MEM_REQ", mem_req, 1'b0);
        check_b("reset IDoneF", idone_f, 1'b0);
        check_b("reset DDoneM", ddone_m, 1'b0);
        check_w("reset InstrF", instr_f, 32'h0);
        check_w("reset ReadDataM", rdata_m, 32'h0);
        check_w("reset MEM_ADDR", mem_addr, 32'h0);
        check_b("reset ERR", err, 1'b0);

        // Reset in the middle of a fetch, then a stray acknowledge.
        tick(); i_req = 1'b1; i_addr = 32'h100;
        tick(); rst = 1'b1;
        #2 check_b("rstmid req up", mem_req, 1'b1);
        tick(); rst = 1'b0; i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hdead_beef;
        #2;
        check_b("rstmid MEM_REQ", mem_req, 1'b0);
        check_b("rstmid IDoneF", idone_f, 1'b0);
        check_w("rstmid InstrF", instr_f, 32'h0);
        tick(); mem_ack = 1'b0;
        #2;
        check_b("rstmid late ack IDoneF", idone_f, 1'b0);
        check_b("rstmid late ack MEM_REQ", mem_req, 1'b0);

        // Fetch acknowledged in its first busy cycle.
        tick(); i_req = 1'b1; i_addr = 32'h40;
        #2 check_b("fetch c0 StallF", stall_f, 1'b1);
        tick(); mem_ack = 1'b1; mem_rdata = 32'h13;
        #2;
        check_b("fetch c1 MEM_REQ", mem_req, 1'b1);
        check_w("fetch c1 MEM_SIZE", 32'(mem_size), 32'd2);
        check_b("fetch c1 MEM_WE", mem_we, 1'b0);
        check_w("fetch c1 MEM_ADDR", mem_addr, 32'h40);
        check_b("fetch c1 StallF", stall_f, 1'b1);
        tick(); mem_ack = 1'b0;
        #2;
        check_b("fetch c2 IDoneF", idone_f, 1'b1);
        check_w("fetch c2 InstrF", instr_f, 32'h13);
        check_b("fetch c2 StallF", stall_f, 1'b0);
        check_b("fetch c2 MEM_REQ", mem_req, 1'b0);
        tick(); i_req = 1'b0;
        #2;
        check_b("fetch c3 IDoneF", idone_f, 1'b0);
        check_w("fetch c3 InstrF hold", instr_f, 32'h13);

        // Store and fetch raised together, each acked after three cycles.
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hcafe_babe;
        d_size = 2'd0; d_sign = 1'b0; i_req = 1'b1; i_addr = 32'h80;
        dd_cnt = 0; id_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            mem_ack = (c == 3 || c == 7);
            mem_rdata = 32'h93;
            if (c == 5) d_req = 1'b0;
            if (c == 9) i_req = 1'b0;
            #2;
            if (ddone_m) dd_cnt++;
            if (idone_f) id_cnt++;
            case (c)
                1: begin
                    check_b("simul first WE", mem_we, 1'b1);
                    check_w("simul first ADDR", mem_addr, 32'h2000);
                    check_w("simul first WDATA", mem_wdata, 32'hcafe_babe);
                end
                4: begin
                    check_b("simul DDoneM", ddone_m, 1'b1);
                    check_b("simul req low at DDone", mem_req, 1'b0);
                end
                5: begin
                    check_b("simul fetch REQ", mem_req, 1'b1);
                    check_w("simul fetch ADDR", mem_addr, 32'h80);
                    check_b("simul fetch WE", mem_we, 1'b0);
                end
                8: begin
                    check_b("simul IDoneF", idone_f, 1'b1);
                    check_w("simul InstrF", instr_f, 32'h93);
                end
                default: ;
            endcase
        end
        check_w("simul DDone count", dd_cnt, 32'd1);
        check_w("simul IDone count", id_cnt, 32'd1);

        // Both requests held, every access acked at once: D, I, D, I.
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_size = 2'd2;
        i_req = 1'b1; i_addr = 32'h200; mem_ack = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            #2;
            if (c % 2 == 1) begin
                check_b("alt REQ", mem_req, 1'b1);
                check_w("alt grant ADDR", mem_addr, (c % 4 == 1) ? 32'h3000 : 32'h200);
            end else begin
                check_b("alt DDoneM", ddone_m, c % 4 == 2);
                check_b("alt IDoneF", idone_f, c % 4 == 0);
            end
        end
        tick(); i_req = 1'b0;
        tick(); d_req = 1'b0; mem_ack = 1'b0;

        // Signed load with five busy cycles.
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3004; d_size = 2'd1; d_sign = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            mem_ack = (c == 5);
            mem_rdata = (c == 5) ? 32'hffff_ff80 : $urandom;
            if (c == 7) d_req = 1'b0;
            #2;
            if (c <= 5) begin
                check_b("load REQ held", mem_req, 1'b1);
                check_w("load ADDR held", mem_addr, 32'h3004);
                check_b("load SIGN held", mem_sign, 1'b1);
            end
            if (c == 6) begin
                check_b("load DDoneM", ddone_m, 1'b1);
                check_w("load ReadDataM", rdata_m, 32'hffff_ff80);
                check_b("load REQ low", mem_req, 1'b0);
            end
        end
        mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // Load that is never acknowledged.
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_size = 2'd2; d_sign = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 6) d_req = 1'b0;
            #2;
            if (c <= 4) check_b("tmo REQ held", mem_req, 1'b1);
            if (c == 5) begin
                check_b("tmo REQ dropped", mem_req, 1'b0);
                check_b("tmo DDoneM", ddone_m, 1'b1);
                check_w("tmo ReadDataM", rdata_m, 32'h0);
                check_b("tmo ERR set", err, 1'b1);
            end
            if (c == 8) check_b("tmo ERR sticky", err, 1'b1);
        end
        rst = 1'b1;
        tick(); rst = 1'b0;
        #2 check_b("tmo ERR cleared", err, 1'b0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst = ($urandom_range(0, 249) == 0);
            if (!i_req || m_idone_prev) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = $urandom;
            end
            if (!d_req || m_ddone_prev) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_size  = 2'($urandom_range(0, 2));
                d_sign  = 1'($urandom_range(0, 1));
            end
            mem_ack   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            mem_rdata = $urandom;
        end

        tick();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        repeat (2) tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shared single-port memory arbiter and access sequencer for the pipelined OTTER core. It multiplexes instruction fetch requests and memory-stage data requests onto one variable-latency memory port. It runs the request/acknowledge handshake and returns read data to the requester. It drives the fetch and memory-stage stall signals that freeze the pipeline registers while an access is outstanding.

## Interface
- `TIMEOUT`, default 255: maximum cycles a granted access may wait for `MEM_ACK`. Used only with `MEM_TIMEOUT_EN`.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `IReqF` in 1: fetch request, level; held until `IDoneF`.
- `IAddrF` in 32: fetch address.
- `InstrF` out 32: fetched word; valid while `IDoneF` is high.
- `IDoneF` out 1: one-cycle fetch completion pulse.
- `StallF` out 1: `IReqF & ~IDoneF`, combinational.
- `DReqM` in 1: data request, level (read or write); held until `DDoneM`.
- `MemWriteM` in 1: 1 = store, 0 = load.
- `ALUResultM` in 32: data address.
- `WriteDataM` in 32: store data.
- `MemSizeM` in 2: access size (0 = byte, 1 = half, 2 = word).
- `MemSignM` in 1: load sign-extend flag; passed through to memory.
- `ReadDataM` out 32: load data; valid while `DDoneM` is high.
- `DDoneM` out 1: one-cycle data completion pulse, for loads and stores.
- `StallM` out 1: `DReqM & ~DDoneM`, combinational.
- `MEM_REQ` out 1: memory request; held high until the cycle `MEM_ACK` is sampled.
- `MEM_WE` out 1, `MEM_ADDR` out 32, `MEM_WDATA` out 32, `MEM_SIZE` out 2, `MEM_SIGN` out 1: registered command. Stable while `MEM_REQ` is high.
- `MEM_ACK` in 1: memory completion; for reads, `MEM_RDATA` is valid in the same cycle.
- `MEM_RDATA` in 32: memory read data.
- `ERR` out 1: sticky timeout flag. Tied to 0 without `MEM_TIMEOUT_EN`.

## Operation
- FSM states: `IDLE`, `BUSY_I`, `BUSY_D`.
- **IDLE arbitration.** A requester whose Done pulse is high this cycle is ineligible, because its request is stale.
  - Data requests have priority over fetch requests.
  - Exception: if the previous grant was data and `IReqF` is eligible, fetch wins. Data is never granted back-to-back while a fetch waits.
- **On grant:**
  - Register the command: `MEM_WE` = `MemWriteM` for data, 0 for fetch; register address, write data, size and sign (fetch uses size = 2, sign = 0).
  - Set `MEM_REQ` = 1 and move to `BUSY_x`.
  - Record the grant type in the last-grant bit.
- **BUSY_x:**
  - Hold `MEM_REQ` and the command until `MEM_ACK`.
  - On `MEM_ACK`: capture `MEM_RDATA` into `InstrF` or `ReadDataM` (stores capture nothing), clear `MEM_REQ`, go to `IDLE`, and assert the matching Done pulse in the next cycle.
- `MEM_ACK` in `IDLE` is ignored.
- `InstrF` and `ReadDataM` hold their last value after the Done pulse.
- **Reset (including mid-access):**
  - State → `IDLE`; last-grant bit → fetch.
  - All outputs 0: `MEM_REQ`, command registers, `InstrF`, `ReadDataM`, Done pulses, `ERR`.
  - Any access in flight is abandoned.
  - A late `MEM_ACK` after reset is ignored.

## Timing
- Request seen in `IDLE` in cycle 0 → `MEM_REQ` high in cycle 1.
- `MEM_ACK` in cycle k (k ≥ 1) → Done and data in cycle k+1; `MEM_REQ` is low in cycle k+1.
- Minimum request-to-Done latency is 2 cycles. The stall is high through cycle k and low in cycle k+1, so the pipeline advances on the edge ending k+1.
- A new grant can occur in the Done cycle (k+1), to the other requester only.
- Both requests arriving in the same `IDLE` cycle: data is served first; fetch is granted in the data Done cycle.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter is cleared on grant and increments each `BUSY` cycle without `MEM_ACK`.
  - When it reaches `TIMEOUT`: drop `MEM_REQ`, go to `IDLE`, pulse the matching Done next cycle with data 32'h0000_0000, and set `ERR` until `RST`.
- `MEM_TIMEOUT_EN` undefined:
  - No counter; `BUSY` waits indefinitely; `ERR` = 0.

## Test plan
- **Reset mid-fetch.** `IReqF` = 1, `IAddrF` = 0x100, `RST` pulsed before `MEM_ACK` → next cycle `MEM_REQ` = 0, `IDoneF` = 0, `InstrF` = 0. A later stray `MEM_ACK` produces no Done.
- **Fetch, one-cycle ack.** `IReqF` = 1, `IAddrF` = 0x0000_0040; `MEM_ACK` in cycle 1 with `MEM_RDATA` = 0x0000_0013 → `IDoneF` = 1 and `InstrF` = 0x13 in cycle 2. `StallF` = 1 in cycles 0–1 and 0 in cycle 2. `MEM_SIZE` = 2, `MEM_WE` = 0.
- **Simultaneous requests.** Store (`ALUResultM` = 0x2000, `WriteDataM` = 0xCAFEBABE, size 0) and fetch both raised in cycle 0, each acked after 3 cycles → memory sees the data command first with `MEM_WE` = 1 and `MEM_WDATA` = 0xCAFEBABE. `DDoneM` pulses once; the fetch is granted in the `DDoneM` cycle; then `IDoneF` pulses once.
- **Alternation.** `DReqM` and `IReqF` held continuously, every access acked in 1 cycle → grants alternate D, I, D, I; each Done is exactly one cycle wide.
- **Load wait states.** Load to 0x3004, `MemSignM` = 1, `MEM_ACK` after 5 cycles with data 0xFFFF_FF80 → `MEM_REQ` and command stable for 5 cycles; `MEM_SIGN` = 1; `ReadDataM` = 0xFFFF_FF80 with `DDoneM` in cycle 6.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT` = 4).** Load never acked → `MEM_REQ` drops after 4 `BUSY` cycles; `DDoneM` pulses with `ReadDataM` = 0; `ERR` = 1 and stays 1 until `RST`.
